uart_tx_arbiter: RTL

Shares the single UART transmit shifter (piso, clock_50M domain) among NUM_REQ byte sources on the system clock, e.g. the CPU TX peripheral and a debug/status source. Round-robin arbitration with a valid/ready handshake per requester. Sequences the shifter's data_ready/tx_busy handshake, synchronising tx_busy into the clock domain. Counts completed frames.

---
 rtl/uart_pkg.sv | 9 +
 rtl/uart_tx_arbiter_rr_pick.sv | 30 +++
 rtl/uart_tx_arbiter.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_pkg;

  typedef enum logic [1:0] {IDLE, LAUNCH, SEND} uart_arb_state_t;

  localparam int UART_CHAR_W       = 8;
  localparam int UART_PISO_DIVIDER = 4096;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid requester at or above ptr_i, wrapping.
module rr_pick
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [IDW-1:0]     ptr_i,
  output logic [IDW-1:0]     winner_o,
  output logic               any_valid_o
);

  logic [IDW-1:0] cand;

  always_comb begin
    winner_o    = '0;
    any_valid_o = 1'b0;
    cand        = ptr_i;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!any_valid_o && valid_i[cand]) begin
        any_valid_o = 1'b1;
        winner_o    = cand;
      end
      // Explicit wrap keeps the candidate in range when NUM_REQ is not a power of two.
      cand = (cand == IDW'(NUM_REQ - 1)) ? '0 : cand + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of the piso UART shifter among NUM_REQ byte sources.
// Optional launch timeout enabled by defining UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int CHAR_W         = UART_CHAR_W,
  parameter int CNT_W          = 16,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*CHAR_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [CHAR_W-1:0]           piso_tx_data,
  output logic                        piso_data_ready,
  input  logic                        piso_tx_busy,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        arb_busy,
  output logic [CNT_W-1:0]            tx_count,
  output logic                        err_timeout
);

  localparam int GID_W = $clog2(NUM_REQ);

  uart_arb_state_t   state_q, state_d;
  logic [GID_W-1:0]  ptr_q, ptr_d;
  logic [GID_W-1:0]  grant_q, grant_d;
  logic [CHAR_W-1:0] data_q, data_d;
  logic              dr_q, dr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              s1_q, s2_q, s3_q;
  logic              busy_rise, busy_fall;
  logic [GID_W-1:0]  winner;
  logic              any_valid;

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_q, to_d;
  logic            err_q, err_d;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDW     (GID_W)
  ) u_rr_pick (
    .valid_i     (req_valid),
    .ptr_i       (ptr_q),
    .winner_o    (winner),
    .any_valid_o (any_valid)
  );

  // tx_busy crosses from the shifter clock; s3 is history for edge detection.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= piso_tx_busy;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign busy_rise = s2_q & ~s3_q;
  assign busy_fall = ~s2_q & s3_q;

  always_comb begin
    req_ready = '0;
    if (state_q == IDLE && !s2_q && any_valid) req_ready[winner] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    data_d  = data_q;
    dr_d    = dr_q;
    cnt_d   = cnt_q;
`ifdef UART_TX_ARB_TIMEOUT_EN
    to_d    = to_q;
    err_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        // A shifter still busy from before a reset must finish before the next launch.
        if (!s2_q && any_valid) begin
          data_d  = req_data[winner*CHAR_W +: CHAR_W];
          grant_d = winner;
          ptr_d   = (winner == GID_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
          dr_d    = 1'b1;
          state_d = LAUNCH;
`ifdef UART_TX_ARB_TIMEOUT_EN
          to_d    = '0;
`endif
        end
      end
      LAUNCH: begin
        if (busy_rise) begin
          dr_d    = 1'b0;
          state_d = SEND;
        end
`ifdef UART_TX_ARB_TIMEOUT_EN
        else if (to_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          dr_d    = 1'b0;
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          to_d = to_q + 1'b1;
        end
`endif
      end
      SEND: begin
        if (busy_fall) begin
          cnt_d   = cnt_q + 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // data_ready is registered so the other clock domain never sees a decode glitch.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      data_q  <= '0;
      dr_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      data_q  <= data_d;
      dr_q    <= dr_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef UART_TX_ARB_TIMEOUT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      to_q  <= '0;
      err_q <= 1'b0;
    end else begin
      to_q  <= to_d;
      err_q <= err_d;
    end
  end
  assign err_timeout = err_q;
`else
  assign err_timeout = 1'b0;
`endif

  assign piso_tx_data    = data_q;
  assign piso_data_ready = dr_q;
  assign grant_id        = grant_q;
  assign arb_busy        = (state_q != IDLE);
  assign tx_count        = cnt_q;

endmodule
